cache_way_ctrl: RTL and testbench

- Parametrised set-associative tag/state controller: owns the tag, MESI and LRU-age arrays for every set, not just one set presented by the caller.
- Per request: hit detection, victim selection, MESI update, LRU aging.
- Serves the trace-driven L1 model. One instance with WAYS=8 is the data cache; one with WAYS=4 is the instruction cache.
- Adds what the single-set version lacks: registered storage, a request/response handshake, invalidate/snoop semantics, a dirty-victim writeback flag, and a multi-cycle clear sweep.

---
 rtl/cache_way_ctrl_if.sv | 30 +++
 rtl/cache_way_ctrl.sv | 254 +++++++++++++++++++++++++
 tb/tb_cache_way_ctrl.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/cache_way_ctrl_if.sv
// Request/response bundle for cache_way_ctrl.
// master: requester (drives req_*, observes req_ready and resp_*).
// slave : controller (drives req_ready and resp_*).
interface cache_way_ctrl_if #(
  parameter int unsigned TAG_W = 12,
  parameter int unsigned IDX_W = 4,
  parameter int unsigned WAY_W = 3
);
  logic             req_valid;
  logic             req_ready;
  logic [3:0]       req_op;
  logic [TAG_W-1:0] req_tag;
  logic [IDX_W-1:0] req_index;
  logic             resp_valid;
  logic             resp_hit;
  logic [WAY_W-1:0] resp_way;
  logic [1:0]       resp_mesi;
  logic             resp_wb;
  logic [TAG_W-1:0] resp_wb_tag;

  modport master (
    output req_valid, req_op, req_tag, req_index,
    input  req_ready, resp_valid, resp_hit, resp_way, resp_mesi, resp_wb, resp_wb_tag
  );

  modport slave (
    input  req_valid, req_op, req_tag, req_index,
    output req_ready, resp_valid, resp_hit, resp_way, resp_mesi, resp_wb, resp_wb_tag
  );
endinterface

// File: rtl/cache_way_ctrl.sv
// Set-associative tag/MESI/LRU-age controller owning the arrays of every set.
// Ports: clk, rst (synchronous, active high), bus (cache_way_ctrl_if.slave):
//   req_valid/req_ready/req_op/req_tag/req_index in, resp_valid strobe plus held
//   resp_hit/resp_way/resp_mesi/resp_wb/resp_wb_tag out.
// Request accepted in IDLE -> LOOK (lookup) -> RESP (write-back + strobe).
module cache_way_ctrl #(
  parameter int unsigned WAYS  = 8,
  parameter int unsigned SETS  = 16,
  parameter int unsigned TAG_W = 12,
  parameter int unsigned IDX_W = $clog2(SETS),
  parameter int unsigned WAY_W = $clog2(WAYS)
) (
  input logic             clk,
  input logic             rst,
  cache_way_ctrl_if.slave bus
);
  localparam logic [3:0] OpRead = 4'd0, OpWrite = 4'd1, OpIfetch = 4'd2, OpInval = 4'd3;
  localparam logic [3:0] OpSnoop = 4'd4, OpClear = 4'd8, OpNop = 4'd9;
  localparam logic [1:0] MesiI = 2'd0, MesiS = 2'd1, MesiE = 2'd2, MesiM = 2'd3;

  typedef enum logic [1:0] {StClear, StIdle, StLook, StResp} state_e;

  logic [TAG_W-1:0] tag_mem_q  [SETS][WAYS];
  logic [1:0]       mesi_mem_q [SETS][WAYS];
  logic [WAY_W-1:0] age_mem_q  [SETS][WAYS];

  state_e           state_q, state_d;
  logic [IDX_W-1:0] clr_idx_q, clr_idx_d;
  logic [3:0]       op_q, op_d;
  logic [TAG_W-1:0] rtag_q, rtag_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             lk_hit_q, lk_hit_d;
  logic [WAY_W-1:0] lk_way_q, lk_way_d;
  logic             resp_valid_q, resp_valid_d, resp_hit_q, resp_hit_d;
  logic [WAY_W-1:0] resp_way_q, resp_way_d;
  logic [1:0]       resp_mesi_q, resp_mesi_d;
  logic             resp_wb_q, resp_wb_d;
  logic [TAG_W-1:0] resp_wb_tag_q, resp_wb_tag_d;

  // Lookup on the captured set: lowest matching way wins, victim prefers lowest invalid.
  logic             hit, inv_found;
  logic [WAY_W-1:0] hit_way, inv_way, lru_way, victim;
  always_comb begin
    hit = 1'b0; hit_way = '0; inv_found = 1'b0; inv_way = '0; lru_way = '0;
    for (int w = int'(WAYS) - 1; w >= 0; w--) begin
      if (tag_mem_q[idx_q][w] == rtag_q && mesi_mem_q[idx_q][w] != MesiI) begin
        hit = 1'b1;
        hit_way = WAY_W'(w);
      end
      if (mesi_mem_q[idx_q][w] == MesiI) begin
        inv_found = 1'b1;
        inv_way = WAY_W'(w);
      end
      if (age_mem_q[idx_q][w] == WAY_W'(WAYS - 1)) lru_way = WAY_W'(w);
    end
    victim = inv_found ? inv_way : lru_way;
  end

  // The update logic is shared: in LOOK it feeds the response registers from the
  // live lookup, in RESP it produces the write-back from the registered lookup.
  // The set cannot change in between, so both evaluations agree.
  logic             sel_hit;
  logic [WAY_W-1:0] sel_way, acc_age;
  assign sel_hit = (state_q == StLook) ? hit : lk_hit_q;
  assign sel_way = (state_q == StLook) ? (hit ? hit_way : victim) : lk_way_q;

  logic [TAG_W-1:0] upd_tag  [WAYS];
  logic [1:0]       upd_mesi [WAYS];
  logic [WAY_W-1:0] upd_age  [WAYS];
  logic             res_hit, res_wb;
  logic [WAY_W-1:0] res_way;
  logic [1:0]       res_mesi;
  logic [TAG_W-1:0] res_wb_tag;
  always_comb begin
    for (int w = 0; w < int'(WAYS); w++) begin
      upd_tag[w]  = tag_mem_q[idx_q][w];
      upd_mesi[w] = mesi_mem_q[idx_q][w];
      upd_age[w]  = age_mem_q[idx_q][w];
    end
    acc_age    = age_mem_q[idx_q][sel_way];
    res_hit    = sel_hit;
    res_way    = sel_way;
    res_mesi   = mesi_mem_q[idx_q][sel_way];
    res_wb     = 1'b0;
    res_wb_tag = '0;
    case (op_q)
      OpRead, OpWrite, OpIfetch: begin
        for (int w = 0; w < int'(WAYS); w++) begin
          if (age_mem_q[idx_q][w] < acc_age) upd_age[w] = age_mem_q[idx_q][w] + WAY_W'(1);
        end
        upd_age[sel_way] = '0;
        if (!sel_hit) begin
          upd_tag[sel_way] = rtag_q;
          upd_mesi[sel_way] = MesiE;
          if (mesi_mem_q[idx_q][sel_way] == MesiM) begin
            res_wb     = 1'b1;
            res_wb_tag = tag_mem_q[idx_q][sel_way];
          end
        end
        if (op_q == OpWrite) upd_mesi[sel_way] = MesiM;
        res_mesi = upd_mesi[sel_way];
      end
      OpInval, OpSnoop: begin
        if (sel_hit) begin
          upd_mesi[sel_way] = (op_q == OpInval) ? MesiI : MesiS;
          res_mesi = upd_mesi[sel_way];
        end else begin
          res_way  = '0;
          res_mesi = MesiI;
        end
      end
      default: begin
        if (!sel_hit) begin
          res_way  = '0;
          res_mesi = MesiI;
        end
      end
    endcase
  end

  // Single write port: the clear sweep or the RESP write-back.
  logic             mem_we;
  logic [IDX_W-1:0] wr_idx;
  logic [TAG_W-1:0] wr_tag  [WAYS];
  logic [1:0]       wr_mesi [WAYS];
  logic [WAY_W-1:0] wr_age  [WAYS];
  always_comb begin
    mem_we = 1'b0;
    wr_idx = idx_q;
    for (int w = 0; w < int'(WAYS); w++) begin
      wr_tag[w]  = upd_tag[w];
      wr_mesi[w] = upd_mesi[w];
      wr_age[w]  = upd_age[w];
    end
    if (state_q == StClear) begin
      mem_we = 1'b1;
      wr_idx = clr_idx_q;
      for (int w = 0; w < int'(WAYS); w++) begin
        wr_tag[w]  = '0;
        wr_mesi[w] = MesiI;
        wr_age[w]  = WAY_W'(w);
      end
    end else if (state_q == StResp && op_q != OpNop) begin
      mem_we = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      tag_mem_q[wr_idx]  <= wr_tag;
      mesi_mem_q[wr_idx] <= wr_mesi;
      age_mem_q[wr_idx]  <= wr_age;
    end
  end

  always_comb begin
    state_d       = state_q;
    clr_idx_d     = clr_idx_q;
    op_d          = op_q;
    rtag_d        = rtag_q;
    idx_d         = idx_q;
    lk_hit_d      = lk_hit_q;
    lk_way_d      = lk_way_q;
    resp_valid_d  = 1'b0;
    resp_hit_d    = resp_hit_q;
    resp_way_d    = resp_way_q;
    resp_mesi_d   = resp_mesi_q;
    resp_wb_d     = resp_wb_q;
    resp_wb_tag_d = resp_wb_tag_q;
    unique case (state_q)
      StClear: begin
        if (clr_idx_q == IDX_W'(SETS - 1)) begin
          state_d   = StIdle;
          clr_idx_d = '0;
        end else begin
          clr_idx_d = clr_idx_q + IDX_W'(1);
        end
      end
      StIdle: begin
        if (bus.req_valid) begin
          op_d   = bus.req_op;
          rtag_d = bus.req_tag;
          idx_d  = bus.req_index;
          if (bus.req_op == OpClear) begin
            state_d   = StClear;
            clr_idx_d = '0;
          end else if (bus.req_op == OpNop) begin
            state_d       = StResp;
            resp_valid_d  = 1'b1;
            resp_hit_d    = 1'b0;
            resp_way_d    = '0;
            resp_mesi_d   = MesiI;
            resp_wb_d     = 1'b0;
            resp_wb_tag_d = '0;
          end else begin
            state_d = StLook;
          end
        end
      end
      StLook: begin
        lk_hit_d      = hit;
        lk_way_d      = sel_way;
        resp_valid_d  = 1'b1;
        resp_hit_d    = res_hit;
        resp_way_d    = res_way;
        resp_mesi_d   = res_mesi;
        resp_wb_d     = res_wb;
        resp_wb_tag_d = res_wb_tag;
        state_d       = StResp;
      end
      StResp: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StClear;
      clr_idx_q     <= '0;
      op_q          <= '0;
      rtag_q        <= '0;
      idx_q         <= '0;
      lk_hit_q      <= 1'b0;
      lk_way_q      <= '0;
      resp_valid_q  <= 1'b0;
      resp_hit_q    <= 1'b0;
      resp_way_q    <= '0;
      resp_mesi_q   <= '0;
      resp_wb_q     <= 1'b0;
      resp_wb_tag_q <= '0;
    end else begin
      state_q       <= state_d;
      clr_idx_q     <= clr_idx_d;
      op_q          <= op_d;
      rtag_q        <= rtag_d;
      idx_q         <= idx_d;
      lk_hit_q      <= lk_hit_d;
      lk_way_q      <= lk_way_d;
      resp_valid_q  <= resp_valid_d;
      resp_hit_q    <= resp_hit_d;
      resp_way_q    <= resp_way_d;
      resp_mesi_q   <= resp_mesi_d;
      resp_wb_q     <= resp_wb_d;
      resp_wb_tag_q <= resp_wb_tag_d;
    end
  end

  assign bus.req_ready   = (state_q == StIdle);
  assign bus.resp_valid  = resp_valid_q;
  assign bus.resp_hit    = resp_hit_q;
  assign bus.resp_way    = resp_way_q;
  assign bus.resp_mesi   = resp_mesi_q;
  assign bus.resp_wb     = resp_wb_q;
  assign bus.resp_wb_tag = resp_wb_tag_q;
endmodule

// File: tb/tb_cache_way_ctrl.sv
// Scoreboard bench for cache_way_ctrl (WAYS=8, SETS=16, TAG_W=12).
module tb_cache_way_ctrl;
  localparam int unsigned TAG_W = 12;
  localparam int unsigned IDX_W = 4;
  localparam int unsigned WAY_W = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  cache_way_ctrl_if #(.TAG_W(TAG_W), .IDX_W(IDX_W), .WAY_W(WAY_W)) bus ();

  cache_way_ctrl #(.WAYS(8), .SETS(16), .TAG_W(TAG_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        hit;
    logic [2:0]  way;
    logic [1:0]  mesi;
    logic        wb;
    logic [11:0] wb_tag;
    int          at;
    string       name;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every response strobe must match the oldest expected entry.
  always @(negedge clk) begin
    if (bus.resp_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_resp: got resp_valid=1 at cycle %0d expected none", cyc);
      end else begin
        mon_e = sb_q.pop_front();
        check({mon_e.name, ".hit"}, int'(bus.resp_hit), int'(mon_e.hit));
        check({mon_e.name, ".way"}, int'(bus.resp_way), int'(mon_e.way));
        check({mon_e.name, ".mesi"}, int'(bus.resp_mesi), int'(mon_e.mesi));
        check({mon_e.name, ".wb"}, int'(bus.resp_wb), int'(mon_e.wb));
        if (mon_e.wb) check({mon_e.name, ".wb_tag"}, int'(bus.resp_wb_tag), int'(mon_e.wb_tag));
        check({mon_e.name, ".latency_cycle"}, cyc, mon_e.at);
      end
    end
  end

  // Called at a negedge; returns at the negedge after acceptance.
  task automatic send(input logic [3:0] op, input logic [11:0] tag, input logic [3:0] idx,
                      input bit push, input bit hold, input logic e_hit, input logic [2:0] e_way,
                      input logic [1:0] e_mesi, input logic e_wb, input logic [11:0] e_wbtag,
                      input string name, output int acc);
    int n;
    n = 0;
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_tag   = tag;
    bus.req_index = idx;
    while (bus.req_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    acc = cyc;
    if (bus.req_ready !== 1'b1) begin
      checks++;
      failures++;
      $display("FAIL %s.accept: got ready=0 for %0d cycles expected 1", name, n);
      bus.req_valid = 1'b0;
    end else begin
      if (push) sb_q.push_back('{hit: e_hit, way: e_way, mesi: e_mesi, wb: e_wb,
                                 wb_tag: e_wbtag, at: cyc + ((op == 4'd9) ? 1 : 2),
                                 name: name});
      @(negedge clk);
      if (!hold) bus.req_valid = 1'b0;
    end
  endtask

  task automatic rq(input logic [3:0] op, input logic [11:0] tag, input logic [3:0] idx,
                    input logic e_hit, input logic [2:0] e_way, input logic [1:0] e_mesi,
                    input logic e_wb, input logic [11:0] e_wbtag, input string name);
    int acc;
    send(op, tag, idx, 1'b1, 1'b0, e_hit, e_way, e_mesi, e_wb, e_wbtag, name, acc);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (sb_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL %s.drain: got %0d responses outstanding expected 0", name, sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic count_sweep(input string name);
    int n;
    n = 0;
    while (bus.req_ready !== 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
    check(name, n, 16);
  endtask

  localparam logic [3:0] RD = 4'd0, WR = 4'd1, IF = 4'd2, INV = 4'd3, SNP = 4'd4;
  localparam logic [3:0] CLR = 4'd8, NOP = 4'd9;

  int a1, a2, a3;

  initial begin
    bus.req_valid = 1'b0;
    bus.req_op    = '0;
    bus.req_tag   = '0;
    bus.req_index = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    count_sweep("reset_sweep_len");
    check("reset_outputs", int'({bus.resp_valid, bus.resp_hit, bus.resp_way, bus.resp_mesi,
                                 bus.resp_wb, bus.resp_wb_tag}), 0);

    // Cold set: first read misses into way 0, repeat hits.
    rq(RD, 12'h0A1, 4'd5, 1'b0, 3'd0, 2'd2, 1'b0, 12'h0, "rd_miss_idx5");
    rq(RD, 12'h0A1, 4'd5, 1'b1, 3'd0, 2'd2, 1'b0, 12'h0, "rd_hit_idx5");
    rq(IF, 12'h0A1, 4'd5, 1'b1, 3'd0, 2'd2, 1'b0, 12'h0, "if_hit_idx5");

    // Fill idx 3 with eight dirty lines; then LRU eviction order is fill order.
    for (int k = 0; k < 8; k++)
      rq(WR, 12'h100 + 12'(k), 4'd3, 1'b0, 3'(k), 2'd3, 1'b0, 12'h0, $sformatf("fill_%0d", k));
    rq(RD, 12'h108, 4'd3, 1'b0, 3'd0, 2'd2, 1'b1, 12'h100, "evict_way0");
    rq(RD, 12'h109, 4'd3, 1'b0, 3'd1, 2'd2, 1'b1, 12'h101, "evict_way1");
    rq(RD, 12'h108, 4'd3, 1'b1, 3'd0, 2'd2, 1'b0, 12'h0, "rd_hit_after_evict");
    rq(WR, 12'h108, 4'd3, 1'b1, 3'd0, 2'd3, 1'b0, 12'h0, "wr_hit_e_to_m");

    // MESI walk on idx 7.
    rq(RD, 12'h2AA, 4'd7, 1'b0, 3'd0, 2'd2, 1'b0, 12'h0, "mesi_rd_x");
    rq(RD, 12'h2BB, 4'd7, 1'b0, 3'd1, 2'd2, 1'b0, 12'h0, "mesi_rd_y");
    rq(SNP, 12'h2AA, 4'd7, 1'b1, 3'd0, 2'd1, 1'b0, 12'h0, "snoop_e_to_s");
    rq(WR, 12'h2AA, 4'd7, 1'b1, 3'd0, 2'd3, 1'b0, 12'h0, "wr_s_to_m");
    rq(SNP, 12'h2BB, 4'd7, 1'b1, 3'd1, 2'd1, 1'b0, 12'h0, "snoop_y");
    rq(INV, 12'h2AA, 4'd7, 1'b1, 3'd0, 2'd0, 1'b0, 12'h0, "inval_m_no_wb");
    rq(SNP, 12'h2AA, 4'd7, 1'b0, 3'd0, 2'd0, 1'b0, 12'h0, "snoop_miss");
    rq(INV, 12'h3FF, 4'd7, 1'b0, 3'd0, 2'd0, 1'b0, 12'h0, "inval_miss");
    rq(RD, 12'h2AA, 4'd7, 1'b0, 3'd0, 2'd2, 1'b0, 12'h0, "refill_lowest_inv");
    rq(RD, 12'h2BB, 4'd7, 1'b1, 3'd1, 2'd1, 1'b0, 12'h0, "y_still_s");
    drain("basic");

    // Back-to-back with req_valid held high.
    send(RD, 12'h011, 4'd9, 1'b1, 1'b1, 1'b0, 3'd0, 2'd2, 1'b0, 12'h0, "stream_0", a1);
    send(WR, 12'h022, 4'd9, 1'b1, 1'b1, 1'b0, 3'd1, 2'd3, 1'b0, 12'h0, "stream_1", a2);
    send(RD, 12'h011, 4'd9, 1'b1, 1'b0, 1'b1, 3'd0, 2'd2, 1'b0, 12'h0, "stream_2", a3);
    check("stream_spacing_01", a2 - a1, 3);
    check("stream_spacing_12", a3 - a2, 3);
    drain("stream");

    rq(NOP, 12'h022, 4'd9, 1'b0, 3'd0, 2'd0, 1'b0, 12'h0, "nop");
    rq(RD, 12'h022, 4'd9, 1'b1, 3'd1, 2'd3, 1'b0, 12'h0, "nop_left_array");
    drain("nop");

    // Reset while the request sits in LOOK: no response, full sweep, set cleared.
    send(RD, 12'h0A1, 4'd5, 1'b0, 1'b0, 1'b0, 3'd0, 2'd0, 1'b0, 12'h0, "aborted", a1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    count_sweep("midlook_sweep_len");
    repeat (4) @(negedge clk);
    rq(RD, 12'h0A1, 4'd5, 1'b0, 3'd0, 2'd2, 1'b0, 12'h0, "post_rst_miss");

    // Clear op after refilling sets.
    rq(WR, 12'h100, 4'd3, 1'b0, 3'd0, 2'd3, 1'b0, 12'h0, "pre_clr_fill3");
    rq(RD, 12'h011, 4'd9, 1'b0, 3'd0, 2'd2, 1'b0, 12'h0, "pre_clr_fill9");
    drain("pre_clear");
    send(CLR, 12'h0, 4'd0, 1'b0, 1'b0, 1'b0, 3'd0, 2'd0, 1'b0, 12'h0, "clear", a1);
    count_sweep("clear_sweep_len");
    rq(RD, 12'h100, 4'd3, 1'b0, 3'd0, 2'd2, 1'b0, 12'h0, "post_clr_miss3");
    rq(RD, 12'h011, 4'd9, 1'b0, 3'd0, 2'd2, 1'b0, 12'h0, "post_clr_miss9");
    rq(RD, 12'h0A1, 4'd5, 1'b0, 3'd0, 2'd2, 1'b0, 12'h0, "post_clr_miss5");
    drain("final");
    repeat (5) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
